// File: rtl/uart_pkg.sv
// Shared types for the UART transceiver: parity mode, receive error flags and FSM state encodings.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } parity_t;

    // Error flags presented alongside each received word, MSB first: {overrun, parity, frame}.
    typedef struct packed {
        logic overrun;
        logic parity;
        logic frame;
    } rx_err_t;

    localparam int ERR_FRAME   = 0;
    localparam int ERR_PARITY  = 1;
    localparam int ERR_OVERRUN = 2;
    localparam int ERR_W       = 3;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Parity bit for the low 'width' bits of data; words are at most 9 bits wide.
    function automatic logic parity_of(input logic [8:0] data, input int width, input parity_t mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < width) p = p ^ data[i];
        end
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO buffering received {err,dat} words; 'mark' sets one flag bit on the newest entry.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH    = 11,
    parameter int DEPTH    = 4,
    parameter int MARK_BIT = WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             mark,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    last_idx;

    assign wr_idx   = wr_ptr[AW-1:0];
    assign rd_idx   = rd_ptr[AW-1:0];
    assign last_idx = wr_idx - AW'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign rdata = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= wdata;
        end else if (mark && !empty) begin
            mem[last_idx][MARK_BIT] <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART with independent TX and RX engines and a valid/ready word interface.
// Define UART_RX_FIFO_EN to buffer received words in an RX_DEPTH-entry FIFO instead of a single register.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int      BAUDRATE   = 115200,
    parameter int      FREQUENCY  = 100000000,
    parameter int      DATA_WIDTH = 8,
    parameter parity_t PARITY     = PARITY_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      RX_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    output logic                  txd,
    input  logic [DATA_WIDTH-1:0] tx_dat,
    input  logic                  tx_stb,
    output logic                  tx_rdy,
    output logic [DATA_WIDTH-1:0] rx_dat,
    output logic                  rx_stb,
    input  logic                  rx_rdy,
    output logic [ERR_W-1:0]      rx_err
);

    // Handshakes: a word moves on a clk edge where stb && rdy; stb and its data hold until then.

    localparam int            DIV       = FREQUENCY / BAUDRATE;
    localparam int            CW        = $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    // ---------------------------------------------------------------- transmitter
    tx_state_t             tx_state;
    tx_state_t             tx_state_nx;
    logic [CW-1:0]         tx_cnt;
    logic [3:0]            tx_bit;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic                  tx_par;
    logic                  tx_up;
    logic                  tx_tick;
    logic                  tx_accept;

    assign tx_tick   = (tx_cnt == DIV_LAST);
    assign tx_accept = tx_stb && tx_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= TX_IDLE;
        else      tx_state <= tx_state_nx;
    end

    always_comb begin
        tx_state_nx = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_accept) tx_state_nx = TX_START;
            TX_START:  if (tx_tick) tx_state_nx = TX_DATA;
            TX_DATA:   if (tx_tick && tx_bit == DATA_LAST)
                           tx_state_nx = (PARITY == PARITY_NONE) ? TX_STOP : TX_PARITY;
            TX_PARITY: if (tx_tick) tx_state_nx = TX_STOP;
            TX_STOP:   if (tx_tick && tx_bit == STOP_LAST) tx_state_nx = TX_IDLE;
            default:   tx_state_nx = TX_IDLE;
        endcase
    end

    always_comb begin
        txd    = 1'b1;
        tx_rdy = 1'b0;
        case (tx_state)
            TX_IDLE:   tx_rdy = tx_up;
            TX_START:  txd = 1'b0;
            TX_DATA:   txd = tx_shift[0];
            TX_PARITY: txd = tx_par;
            default:   txd = 1'b1;
        endcase
    end

    // tx_up keeps tx_rdy low until the first edge after reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_up    <= 1'b0;
        end else begin
            tx_up <= 1'b1;
            if (tx_state == TX_IDLE || tx_tick) tx_cnt <= '0;
            else                                tx_cnt <= tx_cnt + 1'b1;
            if (tx_tick) begin
                if (tx_state != tx_state_nx) tx_bit <= '0;
                else                         tx_bit <= tx_bit + 1'b1;
            end
            if (tx_accept) begin
                tx_shift <= tx_dat;
                tx_par   <= parity_of(9'(tx_dat), DATA_WIDTH, PARITY);
            end else if (tx_state == TX_DATA && tx_tick) begin
                tx_shift <= tx_shift >> 1;
            end
        end
    end

    // ---------------------------------------------------------------- receiver
    rx_state_t             rx_state;
    rx_state_t             rx_state_nx;
    logic                  rx_s1;
    logic                  rx_s2;
    logic                  rx_prev;
    logic                  rx_fall;
    logic [CW-1:0]         rx_cnt;
    logic [3:0]            rx_bit;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  rx_par_err;
    logic                  rx_half;
    logic                  rx_tick;
    logic                  rx_done;
    rx_err_t               rx_new_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev && !rx_s2;
    assign rx_half = (rx_cnt == HALF_LAST);
    assign rx_tick = (rx_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= RX_IDLE;
        else      rx_state <= rx_state_nx;
    end

    // The start bit is re-checked at its middle; later bits are sampled one full bit apart from there.
    always_comb begin
        rx_state_nx = rx_state;
        case (rx_state)
            RX_IDLE:   if (rx_fall) rx_state_nx = RX_START;
            RX_START:  if (rx_half) rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_tick && rx_bit == DATA_LAST)
                           rx_state_nx = (PARITY == PARITY_NONE) ? RX_STOP : RX_PARITY;
            RX_PARITY: if (rx_tick) rx_state_nx = RX_STOP;
            RX_STOP:   if (rx_tick) rx_state_nx = RX_IDLE;
            default:   rx_state_nx = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_done            = (rx_state == RX_STOP) && rx_tick;
        rx_new_err         = '0;
        rx_new_err.parity  = rx_par_err;
        rx_new_err.frame   = !rx_s2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_err <= 1'b0;
        end else begin
            if (rx_state == RX_IDLE || rx_state != rx_state_nx || rx_tick) rx_cnt <= '0;
            else                                                          rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_IDLE) begin
                rx_bit     <= '0;
                rx_par_err <= 1'b0;
            end else if (rx_state == RX_DATA && rx_tick) begin
                rx_bit   <= (rx_state_nx != rx_state) ? 4'd0 : rx_bit + 1'b1;
                rx_shift <= {rx_s2, rx_shift[DATA_WIDTH-1:1]};
            end else if (rx_state == RX_PARITY && rx_tick) begin
                rx_par_err <= (rx_s2 != parity_of(9'(rx_shift), DATA_WIDTH, PARITY));
            end
        end
    end

    // ---------------------------------------------------------------- receive output stage
`ifdef UART_RX_FIFO_EN
    localparam int FW = DATA_WIDTH + ERR_W;

    logic          f_push;
    logic          f_pop;
    logic          f_mark;
    logic          f_full;
    logic          f_empty;
    logic [FW-1:0] f_rdata;

    // A word arriving at a full FIFO is dropped unless a pop frees a slot in the same cycle.
    assign f_pop  = !f_empty && rx_rdy;
    assign f_push = rx_done && (!f_full || f_pop);
    assign f_mark = rx_done && f_full && !f_pop;

    uart_fifo #(
        .WIDTH    (FW),
        .DEPTH    (RX_DEPTH),
        .MARK_BIT (DATA_WIDTH + ERR_OVERRUN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (f_push),
        .wdata ({rx_new_err, rx_shift}),
        .pop   (f_pop),
        .mark  (f_mark),
        .rdata (f_rdata),
        .full  (f_full),
        .empty (f_empty)
    );

    assign rx_stb = !f_empty;
    assign rx_err = f_rdata[FW-1:DATA_WIDTH];
    assign rx_dat = f_rdata[DATA_WIDTH-1:0];
`else
    logic                  rx_stb_q;
    logic [DATA_WIDTH-1:0] rx_dat_q;
    rx_err_t               rx_err_q;

    // An unaccepted word is kept; later arrivals only raise its overrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_stb_q <= 1'b0;
            rx_dat_q <= '0;
            rx_err_q <= '0;
        end else if (rx_done) begin
            if (!rx_stb_q || rx_rdy) begin
                rx_stb_q <= 1'b1;
                rx_dat_q <= rx_shift;
                rx_err_q <= rx_new_err;
            end else begin
                rx_err_q.overrun <= 1'b1;
            end
        end else if (rx_rdy) begin
            rx_stb_q <= 1'b0;
        end
    end

    assign rx_stb = rx_stb_q;
    assign rx_dat = rx_dat_q;
    assign rx_err = rx_err_q;
`endif

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: randomized loopback and injected frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_transceiver;
  import uart_pkg::*;

  localparam int BAUD  = 1_000_000;
  localparam int FREQ  = 16_000_000;
  localparam int DIV   = FREQ / BAUD;
  localparam int DW    = 8;
  localparam int STOPS = 1;
  localparam int DEPTH = 4;
  localparam int NBITS = 1 + DW + 1 + STOPS;
  localparam int EW    = DW + 3;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  // ---------------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          rxd;
  logic          txd;
  logic [DW-1:0] tx_dat = '0;
  logic          tx_stb = 1'b0;
  logic          tx_rdy;
  logic [DW-1:0] rx_dat;
  logic          rx_stb;
  logic          rx_rdy = 1'b0;
  logic [2:0]    rx_err;
  logic          loop_en = 1'b0;
  logic          inj = 1'b1;

  assign rxd = loop_en ? txd : inj;

  uart_transceiver #(
    .BAUDRATE   (BAUD),
    .FREQUENCY  (FREQ),
    .DATA_WIDTH (DW),
    .PARITY     (PARITY_EVEN),
    .STOP_BITS  (STOPS),
    .RX_DEPTH   (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rxd    (rxd),
    .txd    (txd),
    .tx_dat (tx_dat),
    .tx_stb (tx_stb),
    .tx_rdy (tx_rdy),
    .rx_dat (rx_dat),
    .rx_stb (rx_stb),
    .rx_rdy (rx_rdy),
    .rx_err (rx_err)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  int extra_cnt = 0;
  int rdy_mode = 0;  // 0: hold rx_rdy low, 1: random, 2: always high
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line-level frame: start 0, data LSB first, parity bit, stop bit(s).
  task automatic build_frame(input logic [DW-1:0] d, input logic par_bit, input logic stop_bit,
                             output logic [15:0] bits);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1 + i] = d[i];
    bits[1 + DW] = par_bit;
    bits[2 + DW] = stop_bit;
  endtask

  function automatic logic [EW-1:0] model_word(input logic [DW-1:0] d, input logic par_bit,
                                               input logic stop_bit);
    logic par_bad;
    par_bad = (par_bit != (^d));
    return {1'b0, par_bad, ~stop_bit, d};
  endfunction

  // Receive monitor: accepts words according to rdy_mode, compares against exp_q, checks hold stability.
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_dat = '0;
  initial begin
    forever begin
      logic [EW-1:0] e;
      @(negedge clk);
      if (prev_hold && rst) begin
        check("rx_hold_stb", rx_stb, 1);
        check("rx_hold_dat", rx_dat, prev_dat);
      end
      case (rdy_mode)
        0:       rx_rdy = 1'b0;
        1:       rx_rdy = 1'($urandom_range(0, 1));
        default: rx_rdy = 1'b1;
      endcase
      if (rx_stb && rx_rdy && rst) begin
        if (exp_q.size() == 0) begin
          extra_cnt++;
        end else begin
          e = exp_q.pop_front();
          check("rx_dat", rx_dat, e[DW-1:0]);
          check("rx_err", rx_err, e[EW-1:DW]);
        end
      end
      prev_hold = rx_stb && !rx_rdy && rst;
      prev_dat  = rx_dat;
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic send_tx(input logic [DW-1:0] d, input bit check_line);
    logic [15:0] bits;
    int waited;
    waited = 0;
    while (!tx_rdy && waited < 4 * NBITS * DIV) begin
      @(negedge clk);
      waited++;
    end
    check("tx_rdy_wait", tx_rdy, 1);
    if (!tx_rdy) return;
    tx_dat = d;
    tx_stb = 1'b1;
    @(posedge clk);
    #1;
    tx_stb = 1'b0;
    check("tx_rdy_busy", tx_rdy, 0);
    check("tx_start_now", txd, 0);
    if (check_line) begin
      build_frame(d, ^d, 1'b1, bits);
      repeat (DIV / 2) @(posedge clk);
      #1;
      for (int k = 0; k < NBITS; k++) begin
        check($sformatf("tx_bit%0d", k), txd, bits[k]);
        if (k != NBITS - 1) begin
          repeat (DIV) @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic inject(input logic [DW-1:0] d, input logic par_bit, input logic stop_bit);
    logic [15:0] bits;
    build_frame(d, par_bit, stop_bit, bits);
    for (int k = 0; k < NBITS; k++) begin
      inj = bits[k];
      repeat (DIV) @(negedge clk);
    end
    inj = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 30 * NBITS * DIV) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [DW-1:0] d;
    logic          pb;
    logic          sb;
    logic [EW-1:0] t;

    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_tx_rdy", tx_rdy, 0);
    check("rst_rx_stb", rx_stb, 0);
    check("rst_rx_dat", rx_dat, 0);
    check("rst_rx_err", rx_err, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rel_tx_rdy", tx_rdy, 1);
    check("rel_txd", txd, 1);

    // Loopback of random bytes with randomized consumer backpressure.
    loop_en  = 1'b1;
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(model_word(d, ^d, 1'b1));
      send_tx(d, 1'b1);
    end
    wait_drain("loop_drain");
    repeat (2 * DIV) @(negedge clk);

    // Injected frames: stop bit forced low, wrong parity, then random corruptions.
    loop_en = 1'b0;
    exp_q.push_back(model_word(8'h5A, ^8'h5A, 1'b0));
    inject(8'h5A, ^8'h5A, 1'b0);
    wait_drain("frame_err_drain");
    exp_q.push_back(model_word(8'h5A, ~(^8'h5A), 1'b1));
    inject(8'h5A, ~(^8'h5A), 1'b1);
    wait_drain("parity_err_drain");
    for (int i = 0; i < 4; i++) begin
      d  = 8'($urandom_range(0, 255));
      pb = (^d) ^ 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      exp_q.push_back(model_word(d, pb, sb));
      inject(d, pb, sb);
    end
    wait_drain("rand_inject_drain");

    // Short low glitch must not start a frame.
    inj = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    inj = 1'b1;
    repeat (NBITS * DIV + 2 * DIV) @(negedge clk);
    check("glitch_no_stb", rx_stb, 0);

    // Overrun: words arrive while the consumer stalls; only the first CAP are kept.
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      d = 8'(8'h11 * (i + 1));
      if (i < CAP) begin
        exp_q.push_back(model_word(d, ^d, 1'b1));
      end else begin
        t = exp_q.pop_back();
        t[EW-1] = 1'b1;
        exp_q.push_back(t);
      end
      inject(d, ^d, 1'b1);
    end
    check("ovr_stb_held", rx_stb, 1);
    check("ovr_head_dat", rx_dat, 8'h11);
    rdy_mode = 2;
    wait_drain("ovr_drain");

    // Reset in the middle of a loopback frame on both directions.
    loop_en = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    send_tx(8'h3C, 1'b0);
    repeat (5 * DIV) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_txd", txd, 1);
    check("midrst_tx_rdy", tx_rdy, 0);
    check("midrst_rx_stb", rx_stb, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rel_tx_rdy", tx_rdy, 1);
    check("midrst_rel_txd", txd, 1);
    repeat (NBITS * DIV) @(negedge clk);
    check("midrst_no_stb", rx_stb, 0);
    exp_q.push_back(model_word(8'hA5, ^8'hA5, 1'b1));
    send_tx(8'hA5, 1'b1);
    wait_drain("post_rst_drain");

    repeat (2 * DIV) @(negedge clk);
    check("rx_extra_words", extra_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
